// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the fetch/data memory arbiter.
// Arbiter state, transaction owner and the full byte-enable constant.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    DATA
  } owner_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store.
// Data has priority; a starvation counter forces fetch through.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  arb_state_t  state_q;
  arb_state_t  state_d;
  owner_t      owner_q;
  owner_t      winner;
  logic        we_q;
  logic [3:0]  starve_q;
  logic        fetch_win;
  logic        data_win;
  logic        grant;
  logic        resp;

  assign fetch_win = if_req && (!d_req || starve_q == SMAX);
  assign data_win  = d_req && !fetch_win;

  always_comb begin
    winner = NONE;
    if (state_q == IDLE && !reset) begin
      unique case (1'b1)
        fetch_win: winner = FETCH;
        data_win:  winner = DATA;
        default:   winner = NONE;
      endcase
    end
  end

  assign grant  = (winner != NONE) && m_gnt;
  assign if_gnt = grant && (winner == FETCH);
  assign d_gnt  = grant && (winner == DATA);
  assign resp   = (state_q == WAIT) && m_rvalid;

  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_be    = '0;
    m_addr  = '0;
    m_wdata = '0;
    unique case (winner)
      FETCH: begin
        m_req  = 1'b1;
        m_be   = BE_ALL;
        m_addr = if_addr;
      end
      DATA: begin
        m_req   = 1'b1;
        m_we    = d_we;
        m_be    = d_we ? d_be : BE_ALL;
        m_addr  = d_addr;
        m_wdata = d_we ? d_wdata : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = WAIT;
      WAIT:    if (m_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= NONE;
      we_q    <= 1'b0;
    end else if (grant) begin
      owner_q <= winner;
      we_q    <= (winner == DATA) && d_we;
    end
  end

  // Only grants or an idle fetch port move the counter; WAIT holds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (!if_req) begin
        starve_q <= '0;
      end else if (if_gnt) begin
        starve_q <= '0;
      end else if (d_gnt && starve_q != 4'hF) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= resp && (owner_q == FETCH);
      d_rvalid  <= resp && (owner_q == DATA);
      if (resp && owner_q == FETCH) begin
        if_rdata <= m_rdata;
      end
      if (resp && owner_q == DATA) begin
        d_rdata <= we_q ? '0 : m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a simple
// latency-programmable memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  int passes = 0;
  int total  = 0;

  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] mon_exp;

  logic        gnt_en = 1'b1;
  logic        inj = 1'b0;
  int          lat = 1;
  int          cnt;
  logic [31:0] rd;
  logic [31:0] mem [0:255];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  assign m_gnt    = gnt_en;
  assign m_rvalid = (cnt == 1) || inj;
  assign m_rdata  = rd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 0;
      rd  <= '0;
    end else begin
      if (cnt != 0) cnt <= cnt - 1;
      if (m_req && m_gnt) begin
        cnt <= lat;
        rd  <= mem[m_addr[9:2]];
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && if_rvalid) begin
      total++;
      if (if_q.size() == 0) begin
        $display("FAIL if_unexpected_rvalid: got rdata %h expected no response", if_rdata);
      end else begin
        mon_exp = if_q.pop_front();
        if (if_rdata !== mon_exp)
          $display("FAIL if_rdata: got %h expected %h", if_rdata, mon_exp);
        else passes++;
      end
    end
    if (!reset && d_rvalid) begin
      total++;
      if (d_q.size() == 0) begin
        $display("FAIL d_unexpected_rvalid: got rdata %h expected no response", d_rdata);
      end else begin
        mon_exp = d_q.pop_front();
        if (d_rdata !== mon_exp)
          $display("FAIL d_rdata: got %h expected %h", d_rdata, mon_exp);
        else passes++;
      end
    end
  end

  task automatic drain(input string name);
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (if_q.size() == 0 && d_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    total++;
    if (!done)
      $display("FAIL %s_drain: got %0d/%0d pending expected 0/0", name, if_q.size(), d_q.size());
    else passes++;
  endtask

  task automatic test_reset();
    logic [111:0] outs;
    @(negedge clk); #1;
    outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
            m_req, m_we, m_be, m_addr[9:0], m_wdata[7:0]};
    total++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
    else passes++;
    reset = 1'b0;
    @(negedge clk);
    lat = 5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    #1;
    total++;
    if (d_gnt !== 1'b1) $display("FAIL reset_pre_gnt: got %b expected 1", d_gnt);
    else passes++;
    @(negedge clk);
    d_req = 1'b0;
    #1;
    total++;
    if (dut.state_q !== WAIT) $display("FAIL reset_pre_wait: got %0d expected %0d", dut.state_q, WAIT);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
            m_req, m_we, m_be, m_addr[9:0], m_wdata[7:0]};
    total++;
    if (outs !== '0 || dut.state_q !== IDLE)
      $display("FAIL reset_mid_wait: got outs %h state %0d expected 0 state 0", outs, dut.state_q);
    else passes++;
    if_q.delete();
    d_q.delete();
    reset = 1'b0;
    lat = 1;
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    #1;
    total++;
    if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0)
      $display("FAIL reset_stray_rvalid: got if %b d %b expected 0 0", if_rvalid, d_rvalid);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    #1;
    total++;
    if ({if_gnt, d_gnt, m_req, m_we, m_be, m_addr} !== {4'b1010, 4'hF, 32'h8})
      $display("FAIL fetch_req: got gnt %b m_req %b we %b be %h addr %h expected 1 1 0 f 00000008",
               if_gnt, m_req, m_we, m_be, m_addr);
    else passes++;
    if_q.push_back(32'h00208033);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    total++;
    if (if_rvalid !== 1'b0 || m_req !== 1'b0)
      $display("FAIL fetch_cycle1: got rvalid %b m_req %b expected 0 0", if_rvalid, m_req);
    else passes++;
    @(negedge clk); #1;
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h00208033)
      $display("FAIL fetch_cycle2: got rvalid %b rdata %h expected 1 00208033", if_rvalid, if_rdata);
    else passes++;
    drain("fetch");
  endtask

  task automatic test_store_load();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10;
    d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
    #1;
    total++;
    if ({d_gnt, m_req, m_we, m_be, m_addr, m_wdata} !== {3'b111, 4'b0011, 32'h10, 32'hDEADBEEF})
      $display("FAIL store_req: got gnt %b we %b be %h addr %h wdata %h expected 1 1 3 00000010 deadbeef",
               d_gnt, m_we, m_be, m_addr, m_wdata);
    else passes++;
    d_q.push_back(32'h0);
    @(negedge clk);
    d_req = 1'b0;
    drain("store");
    d_req = 1'b1; d_we = 1'b0; d_be = 4'b0001; d_wdata = 32'h12345678;
    #1;
    total++;
    if ({d_gnt, m_we, m_be, m_wdata} !== {2'b10, 4'hF, 32'h0})
      $display("FAIL load_req: got gnt %b we %b be %h wdata %h expected 1 0 f 00000000",
               d_gnt, m_we, m_be, m_wdata);
    else passes++;
    d_q.push_back(32'h0000BEEF);
    @(negedge clk);
    d_req = 1'b0;
    drain("load");
  endtask

  task automatic test_priority();
    bit seen = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    #1;
    total++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0)
      $display("FAIL prio_first: got d_gnt %b if_gnt %b expected 1 0", d_gnt, if_gnt);
    else passes++;
    d_q.push_back(32'h0000BEEF);
    @(negedge clk);
    d_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (d_rvalid) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen || if_gnt !== 1'b1)
      $display("FAIL prio_fetch_next: got rvalid_seen %b if_gnt %b expected 1 1", seen, if_gnt);
    else passes++;
    if (if_gnt) if_q.push_back(32'h00208033);
    @(negedge clk);
    if_req = 1'b0;
    drain("prio");
  endtask

  task automatic test_starvation();
    int  dcount = 0;
    bit  fgot = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (d_gnt) begin
        dcount++;
        d_q.push_back(32'h0000BEEF);
      end
      if (if_gnt) begin
        fgot = 1;
        if_q.push_back(32'h00208033);
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!fgot || dcount != 4)
      $display("FAIL starve_count: got d_gnts %0d fetch %b expected 4 1", dcount, fgot);
    else passes++;
    @(negedge clk);
    if_req = 1'b0;
    d_req = 1'b0;
    #1;
    total++;
    if (dut.starve_q !== 4'd0)
      $display("FAIL starve_reset: got %0d expected 0", dut.starve_q);
    else passes++;
    drain("starve");
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    gnt_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (m_req !== 1'b1 || m_addr !== 32'h10 || d_gnt !== 1'b0)
        $display("FAIL bp_hold%0d: got m_req %b addr %h d_gnt %b expected 1 00000010 0",
                 i, m_req, m_addr, d_gnt);
      else passes++;
      @(negedge clk);
    end
    gnt_en = 1'b1;
    #1;
    total++;
    if (d_gnt !== 1'b1 || m_gnt !== 1'b1)
      $display("FAIL bp_grant: got d_gnt %b m_gnt %b expected 1 1", d_gnt, m_gnt);
    else passes++;
    d_q.push_back(32'h0000BEEF);
    @(negedge clk);
    d_req = 1'b0;
    drain("bp");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[2] = 32'h00208033;
    test_reset();
    test_fetch();
    test_store_load();
    test_priority();
    test_starvation();
    test_back_pressure();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the core's fetch stage (read-only) and its load/store stage (read/write).
- Sits between the core pipeline and the memory model, replacing a separate instruction ROM.
- Keeps one transaction outstanding at a time.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; must be 32.
- STARVE_MAX, 4, consecutive data grants allowed while fetch is pending before fetch is forced to win; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch address, word aligned.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt.
- d_we  in  1  1=store, 0=load.
- d_be  in  4  byte enables for stores.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse; load data valid or store complete.
- d_rdata  out  DATA_W  load data; 0 for stores.
- m_req  out  1  memory request.
- m_we  out  1  memory write.
- m_be  out  4  memory byte enables; 4'hF on reads.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_gnt  in  1  memory accepted m_req this cycle.
- m_rvalid  in  1  memory response, at least 1 cycle after m_gnt.
- m_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values: state=IDLE, owner=NONE, starve_cnt=0. All outputs 0 (if_rdata and d_rdata = 0).
- States:
  - IDLE: arbitrate.
  - WAIT: one transaction outstanding; waiting for m_rvalid.
- Arbitration in IDLE is combinational from the current inputs.
  - Winner = FETCH if if_req && (!d_req || starve_cnt==STARVE_MAX).
  - Otherwise winner = DATA if d_req.
  - Otherwise no winner.
- m_* are muxed combinationally from the winner's inputs; m_req=1 only when a winner exists.
- Fetch winner drives m_we=0 and m_be=4'hF. Data load drives m_be=4'hF regardless of d_be. m_wdata=0 unless the winner is a store.
- On m_gnt in IDLE:
  - Pulse the winner's x_gnt in the same cycle.
  - Latch owner and d_we.
  - Go to WAIT.
- Without m_gnt: no x_gnt; stay in IDLE and re-arbitrate every cycle. The winner may change if inputs change.
- In WAIT: m_req=0; both gnts are 0; requests are ignored.
- On m_rvalid in WAIT:
  - Next cycle, owner's x_rvalid=1 for exactly one cycle.
  - Owner's x_rdata = registered m_rdata, or 0 for stores.
  - State returns to IDLE in that same next cycle, so a new grant can occur in the cycle x_rvalid is high.
  - Transaction latency from x_gnt to x_rvalid = memory latency + 1.
- x_rdata holds its value until the next response to that same port.
- m_rvalid in IDLE is a protocol error: ignore it; no rvalid is generated.
- starve_cnt update, on a grant only:
  - DATA granted while if_req=1: saturating increment.
  - FETCH granted: reset to 0.
  - If if_req=0 in any IDLE cycle: reset to 0.
- Simultaneous requests at starve_cnt<STARVE_MAX: DATA wins.
- Reset asserted mid-transaction: immediate return to IDLE. The outstanding response is dropped and no rvalid is issued. The memory model is reset by the same signal.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic {IDLE, WAIT} arb_state_t;
  - typedef enum logic [1:0] {NONE, FETCH, DATA} owner_t;
  - localparam BE_ALL = 4'hF.
- Single module, no sub-module. The starvation counter is inline, a 4-bit saturating counter.

Test Plan:
- Reset: hold reset 2 cycles mid-WAIT → all outputs 0, state=IDLE; a pending m_rvalid after release produces no rvalid.
- Fetch only: if_req with if_addr=0x8, memory returns 0x00208033 with 1-cycle latency → if_gnt in cycle 0, m_addr=0x8, m_be=F, if_rvalid in cycle 2 with if_rdata=0x00208033.
- Store then load: d_we=1, d_addr=0x10, d_be=4'b0011, d_wdata=0xDEADBEEF → m_we=1, m_be=0011, d_rvalid with d_rdata=0. Then a load of 0x10 → d_rdata=0x0000BEEF.
- Priority: if_req and d_req asserted together, starve_cnt=0 → d_gnt first; if_gnt at the next IDLE arbitration after d_rvalid.
- Starvation: if_req held, d_req re-asserted continuously, STARVE_MAX=4 → exactly 4 d_gnt, then if_gnt; starve_cnt returns to 0.
- Back-pressure: m_gnt held 0 for 3 cycles with d_req → m_req=1 and m_addr stable, no d_gnt until m_gnt=1; d_gnt and m_gnt coincide.
